rysy_bus_mem: RTL and testbench

Parametrised, synthesisable data/instruction memory slave for the rysy_core bus, with a request/ready handshake, a programmable wait-state count and per-byte write enables. It replaces hand-driven `rdata` stimulus in core-level benches and serves as the on-chip RAM behind the core's `addr`/`wdata`/`we`/`be` port. Out-of-range and misaligned accesses are flagged so the bench can check them.

---
 rtl/rysy_bus_mem_if.sv | 27 ++
 rtl/rysy_bus_mem.sv | 149 ++++++++++++++
 tb/tb_rysy_bus_mem.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rysy_bus_mem_if.sv
// Request/response bus between a rysy_core-style requester and the on-chip memory slave.
// Handshake: the master raises req with we/be/addr/wdata and holds them until the cycle
// ready=1; ready is a one-cycle strobe, and rdata/err are meaningful only while ready=1.
interface rysy_bus_mem_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              we;
    logic [NB-1:0]     be;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/rysy_bus_mem.sv
// Word-organised RAM slave with programmable wait states, per-byte write enables and
// registered ready/err/rdata; misaligned and out-of-range accesses answer with err=1.
module rysy_bus_mem #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    rysy_bus_mem_if.slave       bus,
    output logic [1:0]          dbg_state
);
    localparam int          NB     = DATA_W / 8;
    localparam int          OFF_W  = (NB > 1) ? $clog2(NB) : 0;
    localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] OFF_MASK = 32'(NB - 1);
    localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;

    // Request fields captured at acceptance; inputs are ignored afterwards.
    logic              lat_we;
    logic              lat_err;
    logic [NB-1:0]     lat_be;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;

    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // Address decode of the incoming request.
    logic [31:0]      word_full;
    logic             in_err;
    logic [IDX_W-1:0] in_idx;

    always_comb begin
        word_full = bus.addr >> OFF_W;
        in_idx    = word_full[IDX_W-1:0];
        in_err    = ((bus.addr & OFF_MASK) != 32'd0) || (word_full >= 32'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) accept = 1'b1;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (bus.req) accept  = 1'b1;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = (LATENCY > 0) ? WAIT : RESP;
            cnt_d   = LAT_M1;
        end
    end

    // The pending write lands at the edge that ends its RESP cycle.
    logic commit;
    assign commit = (state_q == RESP) && lat_we && !lat_err;

    // Response for the transaction entering RESP at the next edge: a zero-latency
    // acceptance uses live inputs, otherwise the latched fields.
    logic              rsp_we;
    logic              rsp_err;
    logic [IDX_W-1:0]  rsp_idx;
    logic [DATA_W-1:0] rsp_word;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        rsp_we   = accept ? bus.we  : lat_we;
        rsp_err  = accept ? in_err  : lat_err;
        rsp_idx  = accept ? in_idx  : lat_idx;
        rsp_word = mem[rsp_idx];
        // A read accepted in the RESP cycle of a write to the same word sees the new lanes.
        for (int i = 0; i < NB; i++) begin
            if (commit && (lat_idx == rsp_idx) && lat_be[i])
                rsp_word[8*i +: 8] = lat_wdata[8*i +: 8];
        end
        rsp_data = (rsp_we || rsp_err) ? '0 : rsp_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_be    <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_we    <= bus.we;
                lat_err   <= in_err;
                lat_be    <= bus.be;
                lat_idx   <= in_idx;
                lat_wdata <= bus.wdata;
            end
            if (state_d == RESP) begin
                ready_q <= 1'b1;
                err_q   <= rsp_err;
                rdata_q <= rsp_data;
            end else begin
                ready_q <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Storage is deliberately not reset; reset forces IDLE, so no commit can occur during it.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_rysy_bus_mem.sv
// Bench for rysy_bus_mem: three instances (LATENCY 1, 3, 0) driven with directed and random
// transactions; a word-array reference model feeds expected-response queues.
module tb_rysy_bus_mem;
    localparam int N = 3;
    localparam int LATS [N] = '{1, 3, 0};
    localparam int W = 33;
    localparam int MODEL_WORDS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        rst_s   [N];
    logic        req_s   [N];
    logic        we_s    [N];
    logic [3:0]  be_s    [N];
    logic [31:0] addr_s  [N];
    logic [31:0] wdata_s [N];
    wire         ready_s [N];
    wire         err_s   [N];
    wire  [31:0] rdata_s [N];
    wire  [1:0]  state_s [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        rysy_bus_mem_if #(.DATA_W(32)) bus ();
        assign bus.req    = req_s[g];
        assign bus.we     = we_s[g];
        assign bus.be     = be_s[g];
        assign bus.addr   = addr_s[g];
        assign bus.wdata  = wdata_s[g];
        assign ready_s[g] = bus.ready;
        assign err_s[g]   = bus.err;
        assign rdata_s[g] = bus.rdata;

        rysy_bus_mem #(.DATA_W(32), .DEPTH(1024), .LATENCY(LATS[g])) dut (
            .clk       (clk),
            .rst       (rst_s[g]),
            .bus       (bus.slave),
            .dbg_state (state_s[g])
        );
    end

    // Scoreboard state
    logic [W-1:0] exp_q     [N][$];
    int           exp_cyc_q [N][$];
    logic [31:0]  model     [N][MODEL_WORDS];
    int checks   = 0;
    int failures = 0;

    task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s actual=%h required=%h (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready strobe; idle outputs must read zero.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_s[k]) begin
                check(k, "outputs_in_reset", {31'd0, ready_s[k], err_s[k], rdata_s[k]}, 64'd0);
            end else if (ready_s[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL inst%0d unexpected_ready actual=1 required=0 (cycle %0d)", k, cyc);
                end else begin
                    logic [W-1:0] e;
                    int c;
                    e = exp_q[k].pop_front();
                    c = exp_cyc_q[k].pop_front();
                    check(k, "response", {31'd0, err_s[k], rdata_s[k]}, {31'd0, e});
                    check(k, "ready_cycle", 64'(cyc), 64'(c));
                end
            end else begin
                check(k, "idle_outputs", {31'd0, err_s[k], rdata_s[k]}, 64'd0);
            end
        end
    end

    // Issue one transaction at a negedge; while waiting, scramble the (ignored) fields.
    task automatic issue(input int k, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        logic [W-1:0] rsp;
        int  idx;
        bit  e;
        bit  got;
        idx = int'(addr >> 2);
        e   = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
        if (e) begin
            rsp = {1'b1, 32'd0};
        end else if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model[k][idx][8*i +: 8] = wdata[8*i +: 8];
            rsp = '0;
        end else begin
            rsp = {1'b0, model[k][idx]};
        end
        req_s[k] = 1'b1; we_s[k] = we; be_s[k] = be; addr_s[k] = addr; wdata_s[k] = wdata;
        exp_q[k].push_back(rsp);
        exp_cyc_q[k].push_back(cyc + 1 + LATS[k]);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ready_s[k]) got = 1'b1;
            else begin
                we_s[k] = 1'($urandom); be_s[k] = 4'($urandom);
                addr_s[k] = $urandom; wdata_s[k] = $urandom;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL inst%0d ready_timeout actual=none required=ready addr=%h", k, addr);
            exp_q[k].delete();
            exp_cyc_q[k].delete();
        end
        if (!hold) begin
            req_s[k] = 1'b0;
            @(negedge clk);
        end
    endtask

    // Accept a write, reset the instance while it waits, release; nothing may be written.
    task automatic abort_write(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        req_s[k] = 1'b1; we_s[k] = 1'b1; be_s[k] = 4'hf; addr_s[k] = addr; wdata_s[k] = wdata;
        @(negedge clk);
        check(k, "state_wait_before_abort", 64'(state_s[k]), 64'd1);
        rst_s[k] = 1'b0;
        req_s[k] = 1'b0;
        repeat (3) @(negedge clk);
        check(k, "state_idle_in_reset", 64'(state_s[k]), 64'd0);
        rst_s[k] = 1'b1;
        repeat (2) @(negedge clk);
        check(k, "state_idle_after_abort", 64'(state_s[k]), 64'd0);
    endtask

    task automatic random_txn(input int k, input bit hold);
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      a = (32'($urandom_range(0, MODEL_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
        else if (r == 2) a = $urandom | 32'h8000_0000;
        else             a = 32'($urandom_range(0, MODEL_WORDS - 1)) << 2;
        issue(k, 1'($urandom), 4'($urandom), a, $urandom, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_s[k] = 1'b1; req_s[k] = 1'b0; we_s[k] = 1'b0;
            be_s[k] = 4'h0; addr_s[k] = '0; wdata_s[k] = '0;
        end
        #1;
        for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) rst_s[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) check(k, "reset_state", 64'(state_s[k]), 64'd0);

        // Give every modelled word a known value.
        for (int k = 0; k < N; k++)
            for (int w = 0; w < MODEL_WORDS; w++)
                issue(k, 1'b1, 4'hf, 32'(w) << 2, $urandom, w != MODEL_WORDS - 1);

        // LATENCY=1: full word, byte enables, error accesses.
        issue(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 4'b0000, 32'h10, 32'h0, 1'b0);
        issue(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b0);
        issue(0, 1'b0, 4'b0000, 32'h10, 32'h0, 1'b0);
        check(0, "byte_merge_model", {32'd0, model[0][4]}, 64'hDE22BE44);
        issue(0, 1'b1, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b0);
        issue(0, 1'b0, 4'b0000, 32'h2, 32'h0, 1'b0);
        issue(0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        issue(0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0);
        issue(0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);

        // LATENCY=3: read with fields scrambled during WAIT, then a reset-aborted write.
        issue(1, 1'b1, 4'hf, 32'h10, 32'hCAFE0010, 1'b0);
        issue(1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        abort_write(1, 32'h8, 32'h12345678);
        issue(1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0);

        // LATENCY=0: back-to-back write then read of the same word.
        issue(2, 1'b1, 4'hf, 32'h4, 32'hA5A5A5A5, 1'b1);
        issue(2, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1);
        issue(2, 1'b1, 4'b1000, 32'h4, 32'h5A000000, 1'b1);
        issue(2, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);

        // Random traffic with mixed back-to-back and idle gaps.
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 80; t++) random_txn(k, (t != 79) && ($urandom_range(0, 1) == 1));
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) check(k, "queue_drained", 64'(exp_q[k].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
